// File: rtl/dtw_axis_pkg.sv
// Shared state encoding and sizing helper for the DTW AXI-Stream packet master.
package dtw_axis_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      INIT_COUNTER = 2'd1,
      SEND_STREAM  = 2'd2
   } state_e;

   // Ceiling log2, so clogb2(16) = 4 and clogb2(1) = 0.
   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dtw_sync_fifo.sv
// Single-clock FIFO holding {last, data} words ahead of the stream output register.
module dtw_sync_fifo
   import dtw_axis_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [clogb2(DEPTH):0] count
);

   localparam int AW = clogb2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      wr_ok    = wr_en & ~full;
      rd_ok    = rd_en & ~empty;
      // Power-of-two depth lets the pointers wrap by plain overflow.
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/dtw_axis_pkt_master.sv
// AXI4-Stream master that packetises DTW core results buffered in a small FIFO.
module dtw_axis_pkt_master
   import dtw_axis_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 16,
   parameter int PKT_LEN              = 8,
   parameter int C_M_START_COUNT      = 32
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              dtw_fifo_wren,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   dtw_fifo_din,
   input  logic                              dtw_fifo_last,
   output logic                              dtw_fifo_full,
   output logic [clogb2(FIFO_DEPTH):0]       dtw_fifo_count,
   output logic                              dtw_pkt_done,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY
);

   localparam int W      = C_M_AXIS_TDATA_WIDTH;
   localparam int CNT_W  = clogb2(C_M_START_COUNT) + 1;
   localparam int BEAT_W = clogb2(PKT_LEN) + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              tvalid_q, tvalid_d;
   logic [W-1:0]      tdata_q, tdata_d;
   logic              last_bit_q, last_bit_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              pkt_done_q, pkt_done_d;
   logic [W:0]        head;
   logic              fifo_empty, load, hs, tlast;

   dtw_sync_fifo #(
      .WIDTH (W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (M_AXIS_ACLK),
      .rst_n (M_AXIS_ARESETN),
      .wr_en (dtw_fifo_wren),
      .din   ({dtw_fifo_last, dtw_fifo_din}),
      .rd_en (load),
      .dout  (head),
      .full  (dtw_fifo_full),
      .empty (fifo_empty),
      .count (dtw_fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE:         state_d = INIT_COUNTER;
         INIT_COUNTER: begin
            if (wait_cnt_q == CNT_W'(C_M_START_COUNT - 1)) state_d = SEND_STREAM;
            else wait_cnt_d = wait_cnt_q + CNT_W'(1);
         end
         SEND_STREAM:  state_d = SEND_STREAM;
         default:      state_d = IDLE;
      endcase
   end

   // Output register refills from the FIFO head whenever it is empty or being drained.
   always_comb begin
      hs         = tvalid_q & M_AXIS_TREADY;
      tlast      = tvalid_q & (last_bit_q | (beat_q == BEAT_W'(PKT_LEN - 1)));
      load       = (state_q == SEND_STREAM) & ~fifo_empty & (~tvalid_q | M_AXIS_TREADY);
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      last_bit_d = last_bit_q;
      beat_d     = beat_q;
      pkt_done_d = hs & tlast;
      if (load) begin
         tvalid_d   = 1'b1;
         tdata_d    = head[W-1:0];
         last_bit_d = head[W];
      end else if (hs) begin
         tvalid_d   = 1'b0;
      end
      if (hs) beat_d = tlast ? '0 : beat_q + BEAT_W'(1);
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         last_bit_q <= 1'b0;
         beat_q     <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         last_bit_q <= last_bit_d;
         beat_q     <= beat_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TDATA  = tdata_q;
   assign M_AXIS_TLAST  = tlast;
   assign M_AXIS_TSTRB  = '1;
   assign dtw_pkt_done  = pkt_done_q;

endmodule
